// File: rtl/hier_enum_responder.sv
// hier_enum_responder
// Child-side responder for the hierarchy-enumeration protocol. One instance
// runs in each child node. A parent issues requests; this block answers:
//   QUERY (0) : frame = tag, path digits 0..DEPTH-1, child count
//   PING  (1) : single beat = tag, last=1
//   CLR   (2) : clears the query counter, no response
//   op 3      : sets the sticky op_err flag, no response
// Optional feature macro: HIER_ENUM_CHECKSUM_EN
//   Adds a trailing beat to QUERY frames that carries the XOR of all
//   preceding beats. The child-count beat then has rsp_last=0.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_op[1:0], req_tag   : opcode and initiator tag
//   rsp_valid/rsp_ready    : response beat handshake
//   rsp_data[7:0], rsp_last: beat payload and end-of-frame marker
//   query_cnt[CNT_W-1:0]   : saturating count of accepted QUERY ops
//   op_err                 : sticky illegal-opcode flag
module hier_enum_responder #(
  parameter int                         DEPTH        = 10,
  parameter int                         DIGIT_W      = 4,
  parameter logic [DEPTH*DIGIT_W-1:0]   NODE_PATH    = '0,
  parameter int                         NUM_CHILDREN = 5,
  parameter int                         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [7:0]       req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic [CNT_W-1:0] query_cnt,
  output logic             op_err
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] CHILD_B = 8'(NUM_CHILDREN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PATH,
`ifdef HIER_ENUM_CHECKSUM_EN
    S_TAIL,
    S_CHK
`else
    S_TAIL
`endif
  } state_e;

  state_e           state_q;
  logic             ping_q;      // TAIL beat belongs to a PING frame
  logic [IDX_W-1:0] idx_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;
  logic             rsp_last_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
`ifdef HIER_ENUM_CHECKSUM_EN
  logic [7:0]       chk_q;       // XOR of every beat loaded so far in this frame
`endif

  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] cnt_d;

  // Path digits, zero-extended to a byte each.
  logic [DEPTH-1:0][7:0] digit;
  for (genvar g = 0; g < DEPTH; g++) begin : g_digit
    assign digit[g] = 8'(NODE_PATH[g*DIGIT_W +: DIGIT_W]);
  end

  assign idx_d = idx_q + IDX_W'(1);
  assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // Output registers are loaded with the *next* beat on the same edge that
  // retires the current one, so a held-high rsp_ready gives one beat/cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ping_q      <= 1'b0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_last_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
`ifdef HIER_ENUM_CHECKSUM_EN
      chk_q       <= 8'h00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            case (req_op)
              2'd0: begin
                state_q     <= S_HDR;
                ping_q      <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= req_tag;
                rsp_last_q  <= 1'b0;
                cnt_q       <= cnt_d;
`ifdef HIER_ENUM_CHECKSUM_EN
                chk_q       <= req_tag;
`endif
              end
              2'd1: begin
                state_q     <= S_TAIL;
                ping_q      <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= req_tag;
                rsp_last_q  <= 1'b1;
              end
              2'd2:    cnt_q <= '0;
              default: err_q <= 1'b1;
            endcase
          end
        end
        S_HDR: begin
          if (rsp_ready) begin
            state_q    <= S_PATH;
            idx_q      <= '0;
            rsp_data_q <= digit[0];
`ifdef HIER_ENUM_CHECKSUM_EN
            chk_q      <= chk_q ^ digit[0];
`endif
          end
        end
        S_PATH: begin
          if (rsp_ready) begin
            if (idx_q == IDX_W'(DEPTH - 1)) begin
              state_q    <= S_TAIL;
              rsp_data_q <= CHILD_B;
`ifdef HIER_ENUM_CHECKSUM_EN
              rsp_last_q <= 1'b0;
              chk_q      <= chk_q ^ CHILD_B;
`else
              rsp_last_q <= 1'b1;
`endif
            end else begin
              idx_q      <= idx_d;
              rsp_data_q <= digit[idx_d];
`ifdef HIER_ENUM_CHECKSUM_EN
              chk_q      <= chk_q ^ digit[idx_d];
`endif
            end
          end
        end
        S_TAIL: begin
          if (rsp_ready) begin
`ifdef HIER_ENUM_CHECKSUM_EN
            if (!ping_q) begin
              state_q    <= S_CHK;
              rsp_data_q <= chk_q;
              rsp_last_q <= 1'b1;
            end else
`endif
            begin
              state_q     <= S_IDLE;
              rsp_valid_q <= 1'b0;
              rsp_data_q  <= 8'h00;
              rsp_last_q  <= 1'b0;
            end
          end
        end
`ifdef HIER_ENUM_CHECKSUM_EN
        S_CHK: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_last_q  <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign query_cnt = cnt_q;
  assign op_err    = err_q;

endmodule

// File: tb/tb_hier_enum_responder.sv
module tb_hier_enum_responder;

  localparam int          DEPTH   = 10;
  localparam int          DIGIT_W = 4;
  localparam int          NC      = 5;
  localparam int          CNT_W   = 16;
  // digits 0..9 = 0,0,0,0,0,0,0,3,3,0
  localparam logic [39:0] PATH    = 40'h03_3000_0000;
`ifdef HIER_ENUM_CHECKSUM_EN
  localparam int          FN      = DEPTH + 3;
`else
  localparam int          FN      = DEPTH + 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = 2'd0;
  logic [7:0]       req_tag = 8'h00;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [7:0]       rsp_data;
  logic             rsp_last;
  logic [CNT_W-1:0] query_cnt;
  logic             op_err;

  hier_enum_responder #(
    .DEPTH(DEPTH), .DIGIT_W(DIGIT_W), .NODE_PATH(PATH),
    .NUM_CHILDREN(NC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .query_cnt(query_cnt), .op_err(op_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0]  exp_q[$];   // {last, data} beats still owed by the DUT
  logic [8:0]  log_q[$];   // beats actually retired
  int unsigned m_cnt = 0;
  bit          m_err = 1'b0;

  function automatic void add_frame(input logic [1:0] op, input logic [7:0] tag);
    logic [7:0] x;
    logic [7:0] d;
    if (op == 2'd1) exp_q.push_back({1'b1, tag});
    else if (op == 2'd0) begin
      x = tag;
      exp_q.push_back({1'b0, tag});
      for (int i = 0; i < DEPTH; i++) begin
        d = 8'((PATH >> (i * DIGIT_W)) & ((40'd1 << DIGIT_W) - 40'd1));
        exp_q.push_back({1'b0, d});
        x = x ^ d;
      end
`ifdef HIER_ENUM_CHECKSUM_EN
      exp_q.push_back({1'b0, 8'(NC)});
      exp_q.push_back({1'b1, x ^ 8'(NC)});
`else
      exp_q.push_back({1'b1, 8'(NC)});
`endif
    end
  endfunction

  // Compare current outputs, then predict the effect of the coming edge.
  always @(negedge clk) begin
    bit idle;
    idle = (exp_q.size() == 0);
    chk("rsp_valid", rsp_valid, !idle);
    chk("req_ready", req_ready, idle);
    chk("query_cnt", query_cnt, m_cnt);
    chk("op_err", op_err, m_err);
    if (!idle) begin
      chk("rsp_data", rsp_data, exp_q[0][7:0]);
      chk("rsp_last", rsp_last, exp_q[0][8]);
    end
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else if (!idle) begin
      if (rsp_ready) begin
        log_q.push_back({rsp_last, rsp_data});
        void'(exp_q.pop_front());
      end
    end else if (req_valid) begin
      case (req_op)
        2'd0: begin
          add_frame(2'd0, req_tag);
          if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        2'd1: add_frame(2'd1, req_tag);
        2'd2: m_cnt = 0;
        default: m_err = 1'b1;
      endcase
    end
  end

  // ---------------- rsp_ready driver ----------------
  int rdy_mode = 0;   // 0: held high, 1: pattern 1,0,0,1, 2: random
  int ph = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rsp_ready = 1'b1;
      1: begin
        rsp_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [7:0] tag);
    int n = 0;
    bit acc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_tag = tag;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: req_ready never seen for op %0d", op);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 500) begin
      @(negedge clk); #1;
      done = (exp_q.size() == 0) && !rsp_valid && req_ready;
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL idle_timeout: frame did not complete, %0d beats outstanding", exp_q.size());
    end
  endtask

  logic [7:0] e1 [FN];

  task automatic check_frame(input string name);
    chk({name, "_len"}, log_q.size(), FN);
    for (int i = 0; i < FN && i < log_q.size(); i++) begin
      chk({name, "_data"}, log_q[i][7:0], e1[i]);
      chk({name, "_last"}, log_q[i][8], (i == FN - 1));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < FN; i++) e1[i] = 8'h00;
    e1[0] = 8'hA5; e1[8] = 8'h03; e1[9] = 8'h03; e1[11] = 8'h05;
`ifdef HIER_ENUM_CHECKSUM_EN
    e1[12] = 8'hA0;
`endif

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_last", rsp_last, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_query_cnt", query_cnt, 0);
    chk("rst_op_err", op_err, 1'b0);
    rst = 1'b0;

    // plain QUERY, ready held high
    rdy_mode = 0;
    log_q.delete();
    send(2'd0, 8'hA5);
    wait_idle();
    check_frame("q1");
    chk("q1_cnt", query_cnt, 1);

    // same QUERY under 1,0,0,1 backpressure
    rdy_mode = 1;
    log_q.delete();
    send(2'd0, 8'hA5);
    wait_idle();
    check_frame("q2");
    chk("q2_cnt", query_cnt, 2);

    // PING
    rdy_mode = 0;
    log_q.delete();
    send(2'd1, 8'h3C);
    wait_idle();
    chk("ping_len", log_q.size(), 1);
    if (log_q.size() > 0) chk("ping_beat", log_q[0], {1'b1, 8'h3C});
    chk("ping_cnt", query_cnt, 2);

    // three QUERYs, CLR, op 3
    for (int i = 0; i < 3; i++) begin
      send(2'd0, 8'(i));
      wait_idle();
    end
    chk("q3_cnt", query_cnt, 5);
    log_q.delete();
    send(2'd2, 8'h00);
    wait_idle();
    chk("clr_cnt", query_cnt, 0);
    send(2'd3, 8'h00);
    wait_idle();
    chk("op3_err", op_err, 1'b1);
    chk("clr_op3_beats", log_q.size(), 0);

    // reset while beat 5 of a QUERY is presented
    log_q.delete();
    send(2'd0, 8'hA5);
    n = 0;
    while (log_q.size() < 4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_beats_before_rst", log_q.size(), 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_cnt", query_cnt, 0);
    chk("mid_rst_err", op_err, 1'b0);
    log_q.delete();
    send(2'd0, 8'hA5);
    wait_idle();
    check_frame("post_rst");
    chk("post_rst_cnt", query_cnt, 1);

    // randomized traffic, including back-to-back requests while busy
    rdy_mode = 2;
    for (int k = 0; k < 80; k++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r <= 5) ? 2'd0 : (r <= 7) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      send(op, 8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
